// File: rtl/wfifo_pkg.sv
// Shared types and helpers for the write-side front end of the async FIFO.
// Also usable by the read side (gray2bin is width-agnostic up to GRAY_MAX_W bits).
package wfifo_pkg;

    localparam int ADDRSIZE_DEF = 9;
    localparam int DEPTH        = 2**ADDRSIZE_DEF;
    localparam int GRAY_MAX_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } wburst_state_t;

    // Leading zero bits leave the decode unchanged, so narrower pointers are zero-extended in.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_burst_ctrl_sync_ptr.sv
// Multi-flop synchroniser for a Gray-coded FIFO pointer crossing into the local clock.
// Synchronous active-low reset clears every stage.
module sync_ptr #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/wr_burst_ctrl.sv
// Write-domain burst front end of the async FIFO: burst FSM, write handshake,
// rptr synchroniser and fill level. Optional burst abort under `WR_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for burst_req
// BURST | passing producer words to the FIFO until remaining reaches zero
// DONE  | one-cycle completion pulse, then back to IDLE
module wr_burst_ctrl
    import wfifo_pkg::*;
#(
    parameter int ADDRSIZE    = ADDRSIZE_DEF,
    parameter int DATASIZE    = 8,
    parameter int BLEN_W      = 10,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 8
) (
    input  logic                wclk,
    input  logic                w_rst,
    input  logic                burst_req,
    input  logic [BLEN_W-1:0]   burst_len,
    output logic                burst_busy,
    output logic                burst_done,
    input  logic                s_valid,
    input  logic [DATASIZE-1:0] s_data,
    output logic                s_ready,
    output logic                winc,
    output logic [DATASIZE-1:0] wdata,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   waddr,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rptr_sync,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full
`ifdef WR_ABORT_EN
    ,
    input  logic                burst_abort,
    output logic                burst_aborted
`endif
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] FULL_COUNT = PW'(2**ADDRSIZE);
    localparam logic [PW-1:0] AF_LIMIT   = PW'(AF_MARGIN);

    wburst_state_t     state, state_nxt;
    logic [BLEN_W-1:0] remaining, remaining_nxt;
    logic              abort_req;
    logic              aborted_nxt;

`ifdef WR_ABORT_EN
    logic aborted_q;
    assign abort_req     = burst_abort;
    assign burst_aborted = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge wclk) begin
        if (!w_rst) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        s_ready       = 1'b0;
        winc          = 1'b0;
        aborted_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (burst_req) begin
                    if (burst_len != '0) begin
                        state_nxt     = BURST;
                        remaining_nxt = burst_len;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            BURST: begin
                if (abort_req) begin
                    // Abort wins over a pending word: nothing is written this cycle.
                    state_nxt     = DONE;
                    remaining_nxt = '0;
                    aborted_nxt   = 1'b1;
                end else begin
                    s_ready = !wfull;
                    winc    = s_valid && !wfull;
                    if (winc) begin
                        remaining_nxt = remaining - 1'b1;
                        if (remaining == BLEN_W'(1)) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                remaining_nxt = '0;
            end
        endcase
    end

`ifdef WR_ABORT_EN
    always_ff @(posedge wclk) begin
        if (!w_rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_nxt;
        end
    end
`endif

    assign burst_busy = (state != IDLE);
    assign burst_done = (state == DONE);
    assign wdata      = s_data;

    sync_ptr #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_b (w_rst),
        .d     (rptr),
        .q     (rptr_sync)
    );

    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] free_next;

    // Modulo subtraction on the wrap-bit-extended pointers covers wrap without a special case.
    assign rptr_bin   = PW'(gray2bin(GRAY_MAX_W'(rptr_sync)));
    assign level_next = waddr - rptr_bin;
    assign free_next  = FULL_COUNT - level_next;

    always_ff @(posedge wclk) begin
        if (!w_rst) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (free_next <= AF_LIMIT);
        end
    end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Self-checking bench for wr_burst_ctrl: scoreboarded write data, burst timing,
// backpressure, zero-length, mid-burst reset and fill-level/wrap cases.
module tb_wr_burst_ctrl;

    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int BW  = 10;
    localparam int SS  = 2;
    localparam int AFM = 8;

    logic          wclk = 1'b0;
    logic          w_rst;
    logic          burst_req;
    logic [BW-1:0] burst_len;
    logic          burst_busy;
    logic          burst_done;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          wfull;
    logic [AW:0]   waddr;
    logic [AW:0]   rptr;
    logic [AW:0]   rptr_sync;
    logic [AW:0]   wlevel;
    logic          walmost_full;
`ifdef WR_ABORT_EN
    logic          burst_abort = 1'b0;
    logic          burst_aborted;
`endif

    wr_burst_ctrl #(
        .ADDRSIZE    (AW),
        .DATASIZE    (DW),
        .BLEN_W      (BW),
        .SYNC_STAGES (SS),
        .AF_MARGIN   (AFM)
    ) dut (
        .wclk         (wclk),
        .w_rst        (w_rst),
        .burst_req    (burst_req),
        .burst_len    (burst_len),
        .burst_busy   (burst_busy),
        .burst_done   (burst_done),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .waddr        (waddr),
        .rptr         (rptr),
        .rptr_sync    (rptr_sync),
        .wlevel       (wlevel),
        .walmost_full (walmost_full)
`ifdef WR_ABORT_EN
        ,
        .burst_abort  (burst_abort),
        .burst_aborted(burst_aborted)
`endif
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int src_q[$];
    int wr_seen;
    int done_seen;
    int prod_mode;
    logic accepted;
    logic [AW:0] cur_gray;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_prod();
        if (prod_mode != 0) begin
            if (src_q.size() > 0) begin
                s_data  = 8'(src_q[0]);
                s_valid = (prod_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                s_valid = 1'b0;
            end
        end
    endtask

    // Monitor at negedge, then return 1ns after the next posedge with the producer updated.
    task automatic cyc();
        @(negedge wclk);
        accepted = (winc === 1'b1);
        if (wfull === 1'b1) chk("winc_while_full", 32'(winc), 0);
        if (accepted) begin
            if (exp_q.size() == 0) begin
                chk("write_without_expected", 32'(exp_q.size()), 1);
            end else begin
                chk("wdata", 32'(wdata), 32'(exp_q.pop_front()));
            end
            wr_seen++;
        end
        if (burst_done === 1'b1) done_seen++;
        @(posedge wclk);
        #1;
        if (accepted && src_q.size() > 0) void'(src_q.pop_front());
        drive_prod();
    endtask

    task automatic run_burst(input string name, input int len, input int stall_after,
                             input int stall_len, input int mode, input bit check_timing,
                             input int ignore_at);
        int v;
        int stalls;
        int done_at;
        for (int k = 0; k < len; k++) begin
            v = $urandom_range(0, 255);
            src_q.push_back(v);
            exp_q.push_back(v);
        end
        prod_mode = mode;
        drive_prod();
        wr_seen   = 0;
        done_seen = 0;
        stalls    = 0;
        done_at   = -1;
        for (int c = 0; c < 200 && done_at < 0; c++) begin
            wfull     = (stall_len > 0 && wr_seen >= stall_after && stalls < stall_len);
            if (wfull) stalls++;
            burst_req = (c == 0) || (c == ignore_at);
            burst_len = (c == 0) ? BW'(len) : BW'(len + 5);
            cyc();
            if (c == 0) chk({name, "_busy_after_req"}, 32'(burst_busy), 1);
            if (done_seen > 0 && done_at < 0) done_at = c;
        end
        wfull     = 1'b0;
        burst_req = 1'b0;
        chk({name, "_done_reached"}, 32'(done_at >= 0), 1);
        if (check_timing) chk({name, "_done_cycle"}, 32'(done_at), 32'(len + 1 + stall_len));
        cyc();
        chk({name, "_busy_after_done"}, 32'(burst_busy), 0);
        chk({name, "_done_count"}, 32'(done_seen), 1);
        chk({name, "_write_count"}, 32'(wr_seen), 32'(len));
        chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 0);
    endtask

    task automatic lvl(input string name, input logic [AW:0] wa, input logic [AW:0] rbin,
                       input int exp_level, input bit exp_af);
        logic [AW:0] old_gray;
        logic [AW:0] new_gray;
        old_gray = cur_gray;
        new_gray = rbin ^ (rbin >> 1);
        waddr    = wa;
        rptr     = new_gray;
        cur_gray = new_gray;
        for (int i = 1; i <= SS + 1; i++) begin
            cyc();
            if (i == SS - 1) chk({name, "_rsync_early"}, 32'(rptr_sync), 32'(old_gray));
            if (i == SS)     chk({name, "_rsync_latency"}, 32'(rptr_sync), 32'(new_gray));
        end
        chk({name, "_wlevel"}, 32'(wlevel), 32'(exp_level));
        chk({name, "_walmost_full"}, 32'(walmost_full), 32'(exp_af));
    endtask

    initial begin
        prod_mode = 0;
        wr_seen   = 0;
        done_seen = 0;
        cur_gray  = '0;

        // Reset with live-looking inputs
        w_rst     = 1'b0;
        burst_req = 1'b1;
        burst_len = BW'(4);
        s_valid   = 1'b1;
        s_data    = 8'hA5;
        wfull     = 1'b0;
        waddr     = 10'd7;
        rptr      = 10'h155;
        repeat (3) cyc();
        chk("rst_winc", 32'(winc), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_wlevel", 32'(wlevel), 0);
        chk("rst_rptr_sync", 32'(rptr_sync), 0);
        chk("rst_burst_busy", 32'(burst_busy), 0);
        chk("rst_burst_done", 32'(burst_done), 0);
        chk("rst_walmost_full", 32'(walmost_full), 0);

        burst_req = 1'b0;
        s_valid   = 1'b0;
        waddr     = '0;
        rptr      = '0;
        w_rst     = 1'b1;
        repeat (SS + 2) cyc();
        done_seen = 0;

        run_burst("basic",        4, 0, 0, 1, 1'b1, -1);
        run_burst("backpressure", 6, 3, 5, 1, 1'b1, -1);
        run_burst("zero_len",     0, 0, 0, 1, 1'b1, -1);
        run_burst("ignore_req",   5, 0, 0, 1, 1'b1, 2);
        run_burst("random_valid", 7, 2, 3, 2, 1'b0, -1);

        // Mid-burst reset: abandon after three writes
        begin
            int v;
            int guard;
            for (int k = 0; k < 8; k++) begin
                v = $urandom_range(0, 255);
                src_q.push_back(v);
                exp_q.push_back(v);
            end
            prod_mode = 1;
            drive_prod();
            wr_seen   = 0;
            done_seen = 0;
            burst_req = 1'b1;
            burst_len = BW'(8);
            cyc();
            burst_req = 1'b0;
            guard = 0;
            while (wr_seen < 3 && guard < 50) begin
                cyc();
                guard++;
            end
            chk("midrst_three_writes", 32'(wr_seen), 3);
            prod_mode = 0;
            s_valid   = 1'b0;
            w_rst     = 1'b0;
            exp_q.delete();
            src_q.delete();
            cyc();
            s_valid = 1'b1;
            #1;
            chk("midrst_busy", 32'(burst_busy), 0);
            chk("midrst_s_ready", 32'(s_ready), 0);
            chk("midrst_winc", 32'(winc), 0);
            s_valid = 1'b0;
            w_rst   = 1'b1;
            repeat (2) cyc();
            chk("midrst_no_done", 32'(done_seen), 0);
            chk("midrst_idle", 32'(burst_busy), 0);
        end
        run_burst("after_rst", 2, 0, 0, 1, 1'b1, -1);

        // Fill level, almost-full boundary and pointer wrap
        lvl("lvl_505",   10'h3FE, 10'h205, 505, 1'b1);
        lvl("lvl_254",   10'h3FE, 10'h300, 254, 1'b0);
        lvl("lvl_wrap",  10'h003, 10'h3FC,   7, 1'b0);
        lvl("lvl_full",  10'h200, 10'h000, 512, 1'b1);
        lvl("lvl_af_on", 10'h1F8, 10'h000, 504, 1'b1);
        lvl("lvl_af_off",10'h1F7, 10'h000, 503, 1'b0);
        lvl("lvl_empty", 10'h005, 10'h005,   0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
